al422_bam_oe_sequencer: RTL and testbench

Parametrised output-enable sequencer for BAM-driven LED panels. It is the next generation of the fixed-timing OE processor.
- Adds runtime-configurable prescaler and pre/post blanking.
- Adds global brightness (per-unit OE duty).
- Adds abort and a start/busy/done handshake.
- Configurable OE polarity.
It sits between the frame/line controller, which issues one start per bit-plane, and the panel OE pin.

---
 rtl/al422_bam_oe_sequencer.sv | 161 ++++++++++++++++
 tb/tb_al422_bam_oe_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/al422_bam_oe_sequencer.sv
// BAM output-enable sequencer: per bit-plane PRE/ON/POST timing with prescaled units,
// per-unit brightness duty, abort and a start/busy/done handshake. Optional AL422_BAM_OE_OVERRUN_EN.
module al422_bam_oe_sequencer #(
    parameter int PLANE_BITS      = 3,
    parameter int PRESCALER_WIDTH = 8,
    parameter int DELAY_WIDTH     = 4,
    parameter int BRIGHT_WIDTH    = 8,
    parameter bit OE_ACTIVE_LOW   = 1'b1
) (
    input  logic                       in_clk,
    input  logic                       in_nrst,
    input  logic                       start,
    input  logic [PLANE_BITS-1:0]      plane,
    input  logic [PRESCALER_WIDTH-1:0] cfg_prescaler,
    input  logic [DELAY_WIDTH-1:0]     cfg_predelay,
    input  logic [DELAY_WIDTH-1:0]     cfg_postdelay,
    input  logic [BRIGHT_WIDTH-1:0]    cfg_brightness,
    input  logic                       abort,
`ifdef AL422_BAM_OE_OVERRUN_EN
    input  logic                       clr_overrun,
    output logic                       overrun,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       led_oe
);

    localparam int UNIT_W = 2 ** PLANE_BITS;
    localparam int CMP_W  = (PRESCALER_WIDTH > BRIGHT_WIDTH) ? PRESCALER_WIDTH : BRIGHT_WIDTH;
    localparam logic                       OE_IDLE = OE_ACTIVE_LOW;
    localparam logic [UNIT_W-1:0]          UNIT_ONE  = 1;
    localparam logic [DELAY_WIDTH-1:0]     DELAY_ONE = 1;
    localparam logic [PRESCALER_WIDTH-1:0] PHASE_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ON,
        S_POST,
        S_DONE
    } state_t;

    state_t                       state, state_n;
    logic [PRESCALER_WIDTH-1:0]   phase, phase_n;
    logic [UNIT_W-1:0]            units, units_n;
    logic [DELAY_WIDTH-1:0]       dcnt, dcnt_n;
    logic [PRESCALER_WIDTH-1:0]   presc_q;
    logic [DELAY_WIDTH-1:0]       post_q;
    logic [BRIGHT_WIDTH-1:0]      bright_q;
    logic [BRIGHT_WIDTH-1:0]      bright_sel;
    logic                         accept;
    logic                         on_n;

    assign accept = (state == S_IDLE) && start;

    // Brightness is latched on the same edge that enters ON, so bypass the latch while idle.
    assign bright_sel = (state == S_IDLE) ? cfg_brightness : bright_q;

    always_comb begin
        state_n = state;
        phase_n = phase;
        units_n = units;
        dcnt_n  = dcnt;
        case (state)
            S_IDLE: begin
                if (start) begin
                    phase_n = '0;
                    units_n = UNIT_ONE << plane;
                    if (cfg_predelay != '0) begin
                        state_n = S_PRE;
                        dcnt_n  = cfg_predelay;
                    end else begin
                        state_n = S_ON;
                    end
                end
            end
            S_PRE: begin
                if (abort) begin
                    state_n = (post_q != '0) ? S_POST : S_DONE;
                    dcnt_n  = post_q;
                end else if (dcnt == DELAY_ONE) begin
                    state_n = S_ON;
                    phase_n = '0;
                end else begin
                    dcnt_n = dcnt - DELAY_ONE;
                end
            end
            S_ON: begin
                if (abort) begin
                    state_n = (post_q != '0) ? S_POST : S_DONE;
                    dcnt_n  = post_q;
                    phase_n = '0;
                end else if (phase == presc_q) begin
                    phase_n = '0;
                    if (units == UNIT_ONE) begin
                        state_n = (post_q != '0) ? S_POST : S_DONE;
                        dcnt_n  = post_q;
                    end else begin
                        units_n = units - UNIT_ONE;
                    end
                end else begin
                    phase_n = phase + PHASE_ONE;
                end
            end
            S_POST: begin
                if (dcnt == DELAY_ONE) begin
                    state_n = S_DONE;
                end else begin
                    dcnt_n = dcnt - DELAY_ONE;
                end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // OE is registered from the next-state decode so it lines up exactly with ON cycles.
    assign on_n = (state_n == S_ON) && (CMP_W'(phase_n) < CMP_W'(bright_sel));

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state    <= S_IDLE;
            phase    <= '0;
            units    <= '0;
            dcnt     <= '0;
            presc_q  <= '0;
            post_q   <= '0;
            bright_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            led_oe   <= OE_IDLE;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            units  <= units_n;
            dcnt   <= dcnt_n;
            busy   <= (state_n != S_IDLE);
            done   <= (state_n == S_DONE);
            led_oe <= on_n ? ~OE_IDLE : OE_IDLE;
            if (accept) begin
                presc_q  <= cfg_prescaler;
                post_q   <= cfg_postdelay;
                bright_q <= cfg_brightness;
            end
        end
    end

`ifdef AL422_BAM_OE_OVERRUN_EN
    // Sticky early-start flag; a new early start beats a simultaneous clear.
    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            overrun <= 1'b0;
        end else if (start && busy) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_al422_bam_oe_sequencer.sv
// Directed bench for al422_bam_oe_sequencer: per-cycle busy/done/led_oe checks against
// hand-derived timing windows, plus reset, abort, early-start and extreme-length cases.
module tb_al422_bam_oe_sequencer;

    localparam int PB     = 3;
    localparam int PW     = 8;
    localparam int DW     = 4;
    localparam int BW     = 8;
    localparam bit OE_LOW = 1'b1;

    logic          in_clk = 1'b0;
    logic          in_nrst;
    logic          start;
    logic [PB-1:0] plane;
    logic [PW-1:0] cfg_prescaler;
    logic [DW-1:0] cfg_predelay;
    logic [DW-1:0] cfg_postdelay;
    logic [BW-1:0] cfg_brightness;
    logic          abort;
    logic          busy;
    logic          done;
    logic          led_oe;
    logic          oe_act;
`ifdef AL422_BAM_OE_OVERRUN_EN
    logic          clr_overrun;
    logic          overrun;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    assign oe_act = OE_LOW ? ~led_oe : led_oe;

    always #5 in_clk = ~in_clk;

    al422_bam_oe_sequencer #(
        .PLANE_BITS(PB), .PRESCALER_WIDTH(PW), .DELAY_WIDTH(DW),
        .BRIGHT_WIDTH(BW), .OE_ACTIVE_LOW(OE_LOW)
    ) dut (
        .in_clk(in_clk),
        .in_nrst(in_nrst),
        .start(start),
        .plane(plane),
        .cfg_prescaler(cfg_prescaler),
        .cfg_predelay(cfg_predelay),
        .cfg_postdelay(cfg_postdelay),
        .cfg_brightness(cfg_brightness),
        .abort(abort),
`ifdef AL422_BAM_OE_OVERRUN_EN
        .clr_overrun(clr_overrun),
        .overrun(overrun),
`endif
        .busy(busy),
        .done(done),
        .led_oe(led_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    // Clock 0 is the cycle in which start is driven; clock k is the cycle after the k-th edge.
    task automatic run_seq(input string name, input int pl, input int presc, input int pre,
                           input int post, input int bright, input int busy_last,
                           input int on_first, input int on_last, input int abort_at,
                           input int start2_at);
        int  p;
        bit  exp_oe;
        p              = presc + 1;
        plane          = PB'(pl);
        cfg_prescaler  = PW'(presc);
        cfg_predelay   = DW'(pre);
        cfg_postdelay  = DW'(post);
        cfg_brightness = BW'(bright);
        start          = 1'b1;
        abort          = (abort_at == 0);
        for (int k = 1; k <= busy_last + 2; k++) begin
            step();
            start          = (k == start2_at);
            abort          = (k == abort_at);
            plane          = PB'($urandom_range(0, 7));
            cfg_prescaler  = PW'($urandom_range(0, 255));
            cfg_predelay   = DW'($urandom_range(0, 15));
            cfg_postdelay  = DW'($urandom_range(0, 15));
            cfg_brightness = BW'($urandom_range(0, 255));
            exp_oe = (k >= on_first) && (k <= on_last) && (((k - on_first) % p) < bright);
            check($sformatf("%s busy c%0d", name, k), 32'(busy), 32'(k <= busy_last));
            check($sformatf("%s done c%0d", name, k), 32'(done), 32'(k == busy_last));
            check($sformatf("%s oe c%0d", name, k), 32'(oe_act), 32'(exp_oe));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        in_nrst        = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        plane          = '0;
        cfg_prescaler  = '0;
        cfg_predelay   = '0;
        cfg_postdelay  = '0;
        cfg_brightness = '0;
`ifdef AL422_BAM_OE_OVERRUN_EN
        clr_overrun    = 1'b0;
`endif
        repeat (3) step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset led_oe", 32'(led_oe), 32'(OE_LOW));
`ifdef AL422_BAM_OE_OVERRUN_EN
        check("reset overrun", 32'(overrun), 32'd0);
`endif
        in_nrst = 1'b1;
        step();

        // Basic: P=4, pre 2, post 1, plane 2; a second start at clock 5 is ignored.
        run_seq("basic", 2, 3, 2, 1, 255, 20, 3, 18, -1, 5);
`ifdef AL422_BAM_OE_OVERRUN_EN
        check("overrun set", 32'(overrun), 32'd1);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        check("overrun clr", 32'(overrun), 32'd0);
`endif
        // Dimmed, no delays; start in the DONE cycle (clock 9) must not restart.
        run_seq("dim", 1, 3, 0, 0, 1, 9, 1, 8, -1, 9);
        // Abort in ON at clock 6: POST 7..8, DONE 9.
        run_seq("abort_on", 3, 1, 0, 2, 255, 9, 1, 6, 6, -1);
        // Brightness equal to P is full-on; abort alongside start is ignored.
        run_seq("full", 0, 3, 1, 0, 4, 6, 2, 5, 0, -1);
        // P=1 with post delay; abort in POST has no effect.
        run_seq("abort_post", 1, 0, 0, 3, 1, 6, 1, 2, 4, -1);
        // Abort in PRE with no post delay goes straight to DONE.
        run_seq("abort_pre", 2, 1, 5, 0, 255, 3, 99, 0, 2, -1);

        // Asynchronous reset in the middle of ON.
        plane = 2; cfg_prescaler = 3; cfg_predelay = 2; cfg_postdelay = 1; cfg_brightness = 255;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("pre-reset oe", 32'(oe_act), 32'd1);
        #2 in_nrst = 1'b0;
        #1;
        check("async busy", 32'(busy), 32'd0);
        check("async done", 32'(done), 32'd0);
        check("async led_oe", 32'(led_oe), 32'(OE_LOW));
        step();
        in_nrst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            step();
            check($sformatf("post-reset done c%0d", k), 32'(done), 32'd0);
            check($sformatf("post-reset busy c%0d", k), 32'(busy), 32'd0);
        end

        // Extreme: plane 7, P=256, brightness 0 -> 32768 ON clocks, OE never active.
        run_seq("extreme", 7, 255, 0, 0, 0, 32769, 1, 32768, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
